// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its grant mux stage:
// default widths, skid-buffer state encoding and a lowest-set one-hot decoder.
package rr_arb_pkg;

    localparam int unsigned DEFAULT_REQ_WIDTH  = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    // Scanning downwards lets the lowest set bit overwrite any higher one.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides. in_ready_o is a pure
// decode of the registered state so no combinational path runs from
// out_ready_i back to the upstream side.
module rr_skid_buf
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop) begin
                    state_d = ST_FULL;
                end else if (!push && pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                in_ready_o  = 1'b1;
                out_valid_o = 1'b0;
            end
            ST_ONE: begin
                in_ready_o  = 1'b1;
                out_valid_o = 1'b1;
            end
            ST_FULL: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b1;
            end
            default: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b0;
            end
        endcase
    end

    // Entry storage: head feeds the output, skid catches a push while head is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (push) head_q <= in_data_i;
                ST_ONE: begin
                    if (push && pop) begin
                        head_q <= in_data_i;
                    end else if (push) begin
                        skid_q <= in_data_i;
                    end
                end
                ST_FULL:  if (pop) head_q <= skid_q;
                default: begin
                    head_q <= head_q;
                end
            endcase
        end
    end

    assign out_data_o = head_q;

endmodule

// File: rtl/rr_grant_mux.sv
// Downstream stage of the round-robin arbiter: picks the granted requester's
// payload, acks it in the same cycle, and queues {src,data} in a skid buffer.
module rr_grant_mux
    import rr_arb_pkg::*;
#(
    parameter int unsigned REQ_WIDTH  = DEFAULT_REQ_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned SRC_WIDTH  = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_WIDTH-1:0]            req,
    input  logic [REQ_WIDTH-1:0]            grant,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic [REQ_WIDTH-1:0]            ack,
    output logic                            ready_out,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_WIDTH-1:0]            out_src,
    input  logic                            out_ready,
    output logic                            err_grant
);

    localparam int unsigned EntryWidth = SRC_WIDTH + DATA_WIDTH;

    logic [REQ_WIDTH-1:0]  hit;
    int unsigned           hit_idx;
    logic                  capture;
    logic                  buf_in_ready;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [SRC_WIDTH-1:0]  sel_src;
    logic                  bad_grant;
    logic                  err_grant_q, err_grant_d;
    logic [EntryWidth-1:0] buf_out;

    assign hit     = grant & req;
    assign hit_idx = onehot_to_idx(32'(hit));
    assign sel_src = SRC_WIDTH'(hit_idx);

    // The buffer's ready is forced low during reset so nothing is acked then.
    assign ready_out = buf_in_ready && !rst;
    assign capture   = ready_out && (|hit);

    // Payload select and one-hot ack of the lowest granted requester.
    always_comb begin
        sel_data = '0;
        ack      = '0;
        for (int i = 0; i < int'(REQ_WIDTH); i++) begin
            if (hit_idx == unsigned'(i)) begin
                sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                ack[i]   = capture;
            end
        end
    end

    // Multi-hot grant or a grant bit without its request is a protocol error.
    assign bad_grant = ((grant & (grant - 1'b1)) != '0) || ((grant & ~req) != '0);

    // Sticky error flag, cleared only by reset.
    always_comb begin
        err_grant_d = err_grant_q || bad_grant;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_grant_q <= 1'b0;
        end else begin
            err_grant_q <= err_grant_d;
        end
    end

    assign err_grant = err_grant_q;

    rr_skid_buf #(
        .WIDTH(EntryWidth)
    ) u_skid_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (capture),
        .in_data_i  ({sel_src, sel_data}),
        .in_ready_o (buf_in_ready),
        .out_valid_o(out_valid),
        .out_data_o (buf_out),
        .out_ready_i(out_ready)
    );

    assign out_src  = buf_out[EntryWidth-1 -: SRC_WIDTH];
    assign out_data = buf_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rr_grant_mux.sv
// Directed bench for rr_grant_mux with REQ_WIDTH=4, DATA_WIDTH=8, lanes 8'hA0+i.
module tb_rr_grant_mux;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [31:0] in_data;
    logic [3:0]  ack;
    logic        ready_out;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        err_grant;

    int checks   = 0;
    int failures = 0;

    rr_grant_mux #(
        .REQ_WIDTH (4),
        .DATA_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .in_data  (in_data),
        .ack      (ack),
        .ready_out(ready_out),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready),
        .err_grant(err_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; registered outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; grant = 4'b0001; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (ack !== 4'b0000) begin
                failures++; $display("FAIL reset_ack got=%b exp=0000", ack);
            end
            checks++;
            if (ready_out !== 1'b0) begin
                failures++; $display("FAIL reset_ready got=%b exp=0", ready_out);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_valid got=%b exp=0", out_valid);
            end
        end
        checks++;
        if (out_data !== 8'h00 || out_src !== 2'd0 || err_grant !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got data=%h src=%0d err=%b exp 00/0/0",
                     out_data, out_src, err_grant);
        end
        rst = 1'b0; req = 4'b0000; grant = 4'b0000;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=1", ready_out);
        end
    endtask

    task automatic test_single();
        req = 4'b0001; grant = 4'b0001; out_ready = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++; $display("FAIL single_ack got=%b exp=0001", ack);
        end
        tick();
        req = 4'b0000; grant = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_src !== 2'd0) begin
            failures++;
            $display("FAIL single_out got v=%b d=%h s=%0d exp 1/a0/0",
                     out_valid, out_data, out_src);
        end
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL single_ack_drop got=%b exp=0000", ack);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] grants [3];
        logic [7:0] exp_d;
        grants[0] = 4'b0001; grants[1] = 4'b0010; grants[2] = 4'b0100;
        req = 4'b0111; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            grant = grants[c];
            #1;
            checks++;
            if (ack !== grants[c]) begin
                failures++; $display("FAIL rot_ack%0d got=%b exp=%b", c, ack, grants[c]);
            end
            if (c > 0) begin
                exp_d = 8'hA0 + 8'(c - 1);
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d || out_src !== 2'(c - 1)) begin
                    failures++;
                    $display("FAIL rot_out%0d got v=%b d=%h s=%0d exp 1/%h/%0d",
                             c, out_valid, out_data, out_src, exp_d, c - 1);
                end
            end
            tick();
        end
        req = 4'b0000; grant = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_src !== 2'd2) begin
            failures++;
            $display("FAIL rot_out2 got v=%b d=%h s=%0d exp 1/a2/2",
                     out_valid, out_data, out_src);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rot_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req = 4'b1011; grant = 4'b0010;
        #1;
        checks++;
        if (ack !== 4'b0010) begin
            failures++; $display("FAIL bp_ack1 got=%b exp=0010", ack);
        end
        tick();
        grant = 4'b1000;
        #1;
        checks++;
        if (ack !== 4'b1000 || ready_out !== 1'b1) begin
            failures++; $display("FAIL bp_ack2 got ack=%b rdy=%b exp 1000/1", ack, ready_out);
        end
        tick();
        grant = 4'b0001;
        #1;
        checks++;
        if (ack !== 4'b0000 || ready_out !== 1'b0) begin
            failures++; $display("FAIL bp_full got ack=%b rdy=%b exp 0000/0", ack, ready_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_src !== 2'd1) begin
            failures++;
            $display("FAIL bp_hold got v=%b d=%h s=%0d exp 1/a1/1", out_valid, out_data, out_src);
        end
        grant = 4'b0000; req = 4'b0000; out_ready = 1'b1;
        tick();
        checks++;
        if (ready_out !== 1'b1 || out_data !== 8'hA3 || out_src !== 2'd3) begin
            failures++;
            $display("FAIL bp_drain1 got rdy=%b d=%h s=%0d exp 1/a3/3",
                     ready_out, out_data, out_src);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || err_grant !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain2 got v=%b err=%b exp 0/0", out_valid, err_grant);
        end
    endtask

    task automatic test_bad_grant();
        req = 4'b0011; grant = 4'b0011; out_ready = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++; $display("FAIL bad_multi_ack got=%b exp=0001", ack);
        end
        tick();
        req = 4'b0000; grant = 4'b0000;
        #1;
        checks++;
        if (err_grant !== 1'b1 || out_data !== 8'hA0 || out_src !== 2'd0) begin
            failures++;
            $display("FAIL bad_multi_cap got err=%b d=%h s=%0d exp 1/a0/0",
                     err_grant, out_data, out_src);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (err_grant !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_sticky got err=%b v=%b exp 1/0", err_grant, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (err_grant !== 1'b0) begin
            failures++; $display("FAIL bad_rst_clear got=%b exp=0", err_grant);
        end
        req = 4'b0011; grant = 4'b0100;
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL bad_noreq_ack got=%b exp=0000", ack);
        end
        tick();
        req = 4'b0000; grant = 4'b0000;
        #1;
        checks++;
        if (err_grant !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_noreq got err=%b v=%b exp 1/0", err_grant, out_valid);
        end
    endtask

    task automatic test_midop_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0; req = 4'b1010; grant = 4'b0010;
        tick();
        grant = 4'b1000;
        tick();
        checks++;
        if (ready_out !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_full got rdy=%b v=%b exp 0/1", ready_out, out_valid);
        end
        rst = 1'b1; req = 4'b0001; grant = 4'b0001;
        #1;
        checks++;
        if (ack !== 4'b0000 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ack got ack=%b rdy=%b exp 0000/0", ack, ready_out);
        end
        tick();
        rst = 1'b0; req = 4'b0000; grant = 4'b0000; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_state got v=%b d=%h rdy=%b exp 0/00/1",
                     out_valid, out_data, ready_out);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL mid_discard%0d got v=%b d=%h exp v=0",
                                     c, out_valid, out_data);
            end
        end
    endtask

    initial begin
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rst       = 1'b1;
        req       = 4'b0000;
        grant     = 4'b0000;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_bad_grant();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
